// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage data-memory controller for the five-stage pipeline.
// Issues loads/stores to a variable-latency RAM over a req/ready handshake,
// stalls the pipeline until the access completes, and flags misaligned
// word accesses.
// Optional feature macro: DMEM_WBUF_EN (one-entry posted-write buffer).
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_WBUF_EN
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              access;
    logic              aligned;
    logic [ADDR_W-1:0] req_addr;

    // A store with MemReadM also high is treated as a store: MemWriteM alone
    // decides direction.
    assign access   = MemReadM | MemWriteM;
    assign aligned  = (ALUOutM[1:0] == 2'b00);
    assign req_addr = {ALUOutM[ADDR_W-1:2], 2'b00};

    // Next-state and handshake outputs. The RAM request and the load result
    // must be combinational so a zero-wait RAM adds no pipeline latency.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        ReadDataM = '0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        // Reset masks every output; the registers are cleared in always_ff.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (access && !aligned) begin
                        // Suppressed access: the instruction retires with no RAM cycle.
                        MisalignM = 1'b1;
                    end else if (access) begin
                        mem_req   = 1'b1;
                        mem_we    = MemWriteM;
                        mem_addr  = req_addr;
                        mem_wdata = WriteDataM;
                        if (mem_ready) begin
                            if (!MemWriteM) ReadDataM = mem_rdata;
                        end else begin
                            // Hold the request stable from here on, independent of M.
                            addr_d  = req_addr;
                            we_d    = MemWriteM;
                            wdata_d = WriteDataM;
`ifdef DMEM_WBUF_EN
                            if (MemWriteM) begin
                                state_d = DRAIN;
                            end else begin
                                StallM  = 1'b1;
                                state_d = WAIT;
                            end
`else
                            StallM  = 1'b1;
                            state_d = WAIT;
`endif
                        end
                    end
                end
                WAIT: begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    StallM    = !mem_ready;
                    if (mem_ready) begin
                        if (!we_q) ReadDataM = mem_rdata;
                        state_d = IDLE;
                    end
                end
`ifdef DMEM_WBUF_EN
                DRAIN: begin
                    // The posted store owns the RAM. A new access waits through
                    // the completing cycle and is issued from IDLE afterwards,
                    // which keeps write-before-read ordering.
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    StallM    = access;
                    if (mem_ready) state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // State and request latch; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors, multi-cycle sequences and a randomized run
// against a transaction-level reference model of dmem_ctrl.
module tb_dmem_ctrl;

    logic        clk, reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallM, MisalignM;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst, rd, wr;
        logic [31:0] a, wd;
        logic        rdy;
        logic [31:0] rdat;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_stall, e_mis;
        logic [31:0] e_rdd;
    } vec_t;

    function automatic vec_t mk(string nm, logic rst, logic rd, logic wr,
                                logic [31:0] a, logic [31:0] wd, logic rdy,
                                logic [31:0] rdat, logic e_req, logic e_we,
                                logic [31:0] e_addr, logic [31:0] e_wd,
                                logic e_stall, logic e_mis, logic [31:0] e_rdd);
        vec_t v;
        v.nm = nm; v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
        v.rdy = rdy; v.rdat = rdat; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_stall = e_stall;
        v.e_mis = e_mis; v.e_rdd = e_rdd;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic rd, logic wr, logic [31:0] a,
                         logic [31:0] wd, logic rdy, logic [31:0] rdat);
        reset = rst; MemReadM = rd; MemWriteM = wr; ALUOutM = a;
        WriteDataM = wd; mem_ready = rdy; mem_rdata = rdat;
    endtask

    // Apply one cycle, compare mid-cycle, then advance past the edge.
    task automatic step(vec_t v);
        drive(v.rst, v.rd, v.wr, v.a, v.wd, v.rdy, v.rdat);
        #2;
        chk({v.nm, ".req"},   {31'b0, mem_req},   {31'b0, v.e_req});
        chk({v.nm, ".we"},    {31'b0, mem_we},    {31'b0, v.e_we});
        chk({v.nm, ".stall"}, {31'b0, StallM},    {31'b0, v.e_stall});
        chk({v.nm, ".mis"},   {31'b0, MisalignM}, {31'b0, v.e_mis});
        chk({v.nm, ".rdata"}, ReadDataM,          v.e_rdd);
        if (v.e_req) chk({v.nm, ".addr"}, mem_addr, v.e_addr);
        if (v.e_we)  chk({v.nm, ".wdata"}, mem_wdata, v.e_wd);
        @(posedge clk);
        #1;
    endtask

    // Reference model: at most one outstanding RAM transaction, kept in a queue.
    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
        bit          posted;
    } txn_t;
    txn_t pend[$];

    task automatic rand_cycle(int cyc);
        logic rst, rd, wr, rdy, acc;
        logic [31:0] a, wd, rdat;
        logic        x_req, x_we, x_stall, x_mis;
        logic [31:0] x_addr, x_wd, x_rdd;
        bit          wbuf;
        txn_t        t;
`ifdef DMEM_WBUF_EN
        wbuf = 1'b1;
`else
        wbuf = 1'b0;
`endif
        rst  = ($urandom_range(0, 60) == 0);
        rd   = $urandom_range(0, 1) == 1;
        wr   = $urandom_range(0, 2) == 0;
        a    = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        wd   = $urandom;
        rdy  = $urandom_range(0, 2) != 0;
        rdat = $urandom;
        drive(rst, rd, wr, a, wd, rdy, rdat);
        acc = rd | wr;
        x_req = 0; x_we = 0; x_stall = 0; x_mis = 0;
        x_addr = 0; x_wd = 0; x_rdd = 0;
        if (!rst) begin
            if (pend.size() == 0) begin
                if (acc && a[1:0] != 0) x_mis = 1;
                else if (acc) begin
                    x_req = 1; x_we = wr; x_addr = a; x_wd = wd;
                    if (rdy) x_rdd = wr ? 32'h0 : rdat;
                    else x_stall = !(wbuf && wr);
                end
            end else begin
                t = pend[0];
                x_req = 1; x_we = t.we; x_addr = t.a; x_wd = t.d;
                if (t.posted) x_stall = acc;
                else begin
                    x_stall = !rdy;
                    if (rdy && !t.we) x_rdd = rdat;
                end
            end
        end
        #2;
        chk($sformatf("rnd%0d.req", cyc),   {31'b0, mem_req},   {31'b0, x_req});
        chk($sformatf("rnd%0d.we", cyc),    {31'b0, mem_we},    {31'b0, x_we});
        chk($sformatf("rnd%0d.stall", cyc), {31'b0, StallM},    {31'b0, x_stall});
        chk($sformatf("rnd%0d.mis", cyc),   {31'b0, MisalignM}, {31'b0, x_mis});
        chk($sformatf("rnd%0d.rdata", cyc), ReadDataM, x_rdd);
        if (x_req) chk($sformatf("rnd%0d.addr", cyc), mem_addr, x_addr);
        if (x_we)  chk($sformatf("rnd%0d.wdata", cyc), mem_wdata, x_wd);
        @(posedge clk);
        #1;
        if (rst) pend.delete();
        else if (pend.size() == 0) begin
            if (acc && a[1:0] == 0 && !rdy) begin
                t.a = a; t.we = wr; t.d = wd; t.posted = wbuf && wr;
                pend.push_back(t);
            end
        end else if (rdy) void'(pend.pop_front());
    endtask

    vec_t tbl[$];

    initial begin
        // name rst rd wr addr wdata rdy rdata | req we addr wdata stall mis rdata
        tbl.push_back(mk("reset",     1,1,0,32'h40,32'h0,  1,32'hDEAD0000, 0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("zw_load",   0,1,0,32'h40,32'h0,  1,32'hDEADBEEF, 1,0,32'h40, 32'h0, 0,0,32'hDEADBEEF));
        tbl.push_back(mk("idle",      0,0,0,32'h44,32'h0,  1,32'h55,       0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("w3_c1",     0,1,0,32'h40,32'h0,  0,32'h11,       1,0,32'h40, 32'h0, 1,0,32'h0));
        tbl.push_back(mk("w3_c2",     0,1,0,32'h80,32'h0,  0,32'h22,       1,0,32'h40, 32'h0, 1,0,32'h0));
        tbl.push_back(mk("w3_c3",     0,0,1,32'h84,32'h99, 0,32'h33,       1,0,32'h40, 32'h0, 1,0,32'h0));
        tbl.push_back(mk("w3_done",   0,1,0,32'hC0,32'h0,  1,32'hCAFEF00D, 1,0,32'h40, 32'h0, 0,0,32'hCAFEF00D));
        tbl.push_back(mk("w3_idle",   0,0,0,32'h0, 32'h0,  0,32'h0,        0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("mis_ld",    0,1,0,32'h42,32'h0,  1,32'h1234,     0,0,32'h0,  32'h0, 0,1,32'h0));
        tbl.push_back(mk("mis_after", 0,0,0,32'h42,32'h0,  1,32'h1234,     0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("mis_st",    0,0,1,32'h43,32'h7,  0,32'h0,        0,0,32'h0,  32'h0, 0,1,32'h0));
        tbl.push_back(mk("rw_start",  0,1,0,32'h100,32'h0, 0,32'h0,        1,0,32'h100,32'h0, 1,0,32'h0));
        tbl.push_back(mk("rw_reset",  1,1,0,32'h100,32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("rw_idle",   0,0,0,32'h100,32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,0,32'h0));
        tbl.push_back(mk("rw_zwload", 0,1,0,32'h40,32'h0,  1,32'hDEADBEEF, 1,0,32'h40, 32'h0, 0,0,32'hDEADBEEF));
        tbl.push_back(mk("zw_store",  0,0,1,32'h10,32'hAA, 1,32'h77,       1,1,32'h10, 32'hAA,0,0,32'h0));
        tbl.push_back(mk("rdwr_st",   0,1,1,32'h20,32'h5,  1,32'h9,        1,1,32'h20, 32'h5, 0,0,32'h0));
        foreach (tbl[i]) step(tbl[i]);

`ifdef DMEM_WBUF_EN
        // Posted store, then a load that must wait for the drain.
        step(mk("wb_st",    0,0,1,32'h200,32'h1234,0,32'h0,  1,1,32'h200,32'h1234,0,0,32'h0));
        step(mk("wb_ld_w",  0,1,0,32'h300,32'h0,   0,32'h0,  1,1,32'h200,32'h1234,1,0,32'h0));
        step(mk("wb_ld_dn", 0,1,0,32'h300,32'h0,   1,32'h5,  1,1,32'h200,32'h1234,1,0,32'h0));
        step(mk("wb_ld_is", 0,1,0,32'h300,32'h0,   1,32'hAB, 1,0,32'h300,32'h0,   0,0,32'hAB));
        // Non-access cycles during a drain do not stall.
        step(mk("wb_st2",   0,0,1,32'h204,32'h55,  0,32'h0,  1,1,32'h204,32'h55,  0,0,32'h0));
        step(mk("wb_nop",   0,0,0,32'h0,  32'h0,   0,32'h0,  1,1,32'h204,32'h55,  0,0,32'h0));
        step(mk("wb_nopdn", 0,0,0,32'h0,  32'h0,   1,32'h0,  1,1,32'h204,32'h55,  0,0,32'h0));
        step(mk("wb_idle",  0,0,0,32'h0,  32'h0,   1,32'h0,  0,0,32'h0,  32'h0,   0,0,32'h0));
`else
        // Store with two wait cycles; data held while WriteDataM changes.
        step(mk("st_w1",    0,0,1,32'h200,32'h1234,0,32'h0,  1,1,32'h200,32'h1234,1,0,32'h0));
        step(mk("st_w2",    0,0,1,32'h204,32'hFFFF,0,32'h0,  1,1,32'h200,32'h1234,1,0,32'h0));
        step(mk("st_done",  0,0,1,32'h208,32'hEEEE,1,32'h66, 1,1,32'h200,32'h1234,0,0,32'h0));
        step(mk("st_idle",  0,0,0,32'h0,  32'h0,   1,32'h0,  0,0,32'h0,  32'h0,   0,0,32'h0));
`endif

        // Randomized run against the transaction model, from a clean reset.
        step(mk("rnd_rst",  1,0,0,32'h0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0,0,32'h0));
        pend.delete();
        for (int c = 0; c < 3000; c++) rand_cycle(c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
